// File: rtl/mux_scan_nch.sv
// Registered N-channel, W-bit multiplexer with manual select and timed auto-scan.
// Reports the displayed channel and pulses on channel change and scan wrap-around.
module mux_scan_nch #(
  parameter int WIDTH = 2,
  parameter int NCH   = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic                     hold,
  input  logic [NCH*WIDTH-1:0]     in_bus,
  output logic [WIDTH-1:0]         out_m,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic                     ch_changed,
  output logic                     scan_wrap
);

  localparam int SELW = $clog2(NCH);
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_MAX  = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);

  logic [WIDTH-1:0] ch_s [NCH];
  logic [SELW-1:0]  next_ch_s;
  logic [CNTW-1:0]  cnt_r;
  logic [CNTW-1:0]  cnt_nxt_s;
  logic             wrap_s;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch_s[k] = in_bus[k*WIDTH +: WIDTH];
  end

  // Channel selection and dwell counter next-state.
  always_comb begin
    next_ch_s = out_ch;
    cnt_nxt_s = cnt_r;
    wrap_s    = 1'b0;
    if (mode == 1'b0) begin
      cnt_nxt_s = '0;
      // An out-of-range select keeps the current channel so out_m stays valid.
      if ({1'b0, sel} < NCH_W) begin
        next_ch_s = sel;
      end else begin
        next_ch_s = out_ch;
      end
    end else if (hold == 1'b1) begin
      next_ch_s = out_ch;
      cnt_nxt_s = cnt_r;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = '0;
      if (out_ch == CH_MAX) begin
        next_ch_s = '0;
        wrap_s    = 1'b1;
      end else begin
        next_ch_s = out_ch + 1'b1;
      end
    end else begin
      cnt_nxt_s = cnt_r + 1'b1;
    end
  end

  // Output and counter registers; out_m samples live data of the next channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_m      <= '0;
      out_ch     <= '0;
      cnt_r      <= '0;
      ch_changed <= 1'b0;
      scan_wrap  <= 1'b0;
    end else begin
      out_m      <= ch_s[next_ch_s];
      out_ch     <= next_ch_s;
      cnt_r      <= cnt_nxt_s;
      ch_changed <= (next_ch_s != out_ch);
      scan_wrap  <= wrap_s;
    end
  end

endmodule
